// File: rtl/aclk_pkg.sv
// Alarm-clock control package: state encoding, key constants, output bundle
// and the digit-test helper shared by the FSM, key register and display blocks.
package aclk_pkg;

  localparam int unsigned KEY_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [KEY_W-1:0] NOKEY   = 4'd10;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  // Seven states; encoding 3'd7 is unused and recovers to SHOW_TIME.
  typedef enum logic [STATE_W-1:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_e;

  // Control strobes driven by the FSM.
  typedef struct packed {
    logic shift;
    logic show_new_time;
    logic show_a;
    logic load_new_a;
    logic load_new_c;
  } ctl_t;

  // Codes 0..9 are digits; 10 and 11..15 all mean "no key".
  function automatic logic is_digit(input logic [KEY_W-1:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// Key-entry inactivity counter.
// Ports: clock, reset (sync, active-high), clear (hold at zero), tick (one_second),
//        limit (timeout in ticks), expired (combinational: tick lands on limit-1).
module aclk_timeout_cnt
  import aclk_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear dominates; count saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = tick && (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/aclk_fsm.sv
// Alarm-clock key-entry / display-mode controller.
// Ports: clock, reset (sync, active-high), one_second (1-cycle tick), key (4-bit code),
//        alarm_button, time_button (levels); outputs shift, show_new_time, show_a,
//        load_new_a, load_new_c (Moore, registered alongside the state).
module aclk_fsm
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             one_second,
  input  logic [KEY_W-1:0] key,
  input  logic             alarm_button,
  input  logic             time_button,
  output logic             shift,
  output logic             show_new_time,
  output logic             show_a,
  output logic             load_new_a,
  output logic             load_new_c
);

  state_e state_q;
  state_e state_d;
  ctl_t   ctl_q;
  ctl_t   ctl_d;
  logic   cnt_clear;
  logic   timeout;
  logic   digit;

  assign digit     = is_digit(key);
  // Counter only runs while a key is held or the entry is idling.
  assign cnt_clear = (state_q != KEY_WAITED) && (state_q != KEY_ENTRY);

  aclk_timeout_cnt u_timeout_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .tick    (one_second),
    .limit   (CNT_W'(TIMEOUT_SEC)),
    .expired (timeout)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button)   state_d = SHOW_ALARM;
        else if (digit)     state_d = KEY_STORED;
      end
      KEY_STORED:           state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!digit)         state_d = KEY_ENTRY;
        else if (timeout)   state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     state_d = SET_ALARM_TIME;
        else if (time_button) state_d = SET_CURRENT_TIME;
        else if (digit)       state_d = KEY_STORED;
        else if (timeout)     state_d = SHOW_TIME;
      end
      SHOW_ALARM,
      SET_ALARM_TIME: begin
        if (!alarm_button)  state_d = SHOW_TIME;
      end
      SET_CURRENT_TIME: begin
        if (!time_button)   state_d = SHOW_TIME;
      end
      default:              state_d = SHOW_TIME;
    endcase
  end

  // Output decode of the next state, so registered outputs track state_q exactly.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      KEY_STORED: begin
        ctl_d.shift         = 1'b1;
        ctl_d.show_new_time = 1'b1;
      end
      KEY_WAITED,
      KEY_ENTRY:        ctl_d.show_new_time = 1'b1;
      SHOW_ALARM:       ctl_d.show_a        = 1'b1;
      SET_ALARM_TIME:   ctl_d.load_new_a    = 1'b1;
      SET_CURRENT_TIME: ctl_d.load_new_c    = 1'b1;
      default:          ctl_d = '0;
    endcase
  end

  assign shift         = ctl_q.shift;
  assign show_new_time = ctl_q.show_new_time;
  assign show_a        = ctl_q.show_a;
  assign load_new_a    = ctl_q.load_new_a;
  assign load_new_c    = ctl_q.load_new_c;

endmodule

// File: doc/aclk_fsm.md
AClK_FSM -- requirements
Module: aclk_fsm

Interface
REQ-001 Parameter TIMEOUT_SEC, default 10: number of one_second ticks of key-entry inactivity before the entry is abandoned (legal range 2..15).
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 one_second  input  1  one-cycle pulse, once per second.
REQ-005 key  input  4  keypad code; 0..9 = digit, 10 = NOKEY, 11..15 treated as NOKEY.
REQ-006 alarm_button  input  1  level, high while the alarm button is held.
REQ-007 time_button  input  1  level, high while the time button is held.
REQ-008 shift  output  1  one-cycle strobe telling the key register to shift in key.
REQ-009 show_new_time  output  1  high while a key entry is in progress; display shows the key buffer.
REQ-010 show_a  output  1  high while the stored alarm time is displayed.
REQ-011 load_new_a  output  1  load the key buffer into the alarm register.
REQ-012 load_new_c  output  1  load the key buffer into the current-time counter.

Function
REQ-013 The FSM SHALL have seven states: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME.
REQ-014 SHOW_TIME SHALL go to SHOW_ALARM if alarm_button=1, else to KEY_STORED if key is a digit, else stay; time_button is ignored here.
REQ-015 KEY_STORED SHALL last exactly one cycle and then go unconditionally to KEY_WAITED.
REQ-016 KEY_WAITED SHALL go to KEY_ENTRY when key is NOKEY (key released), else to SHOW_TIME on timeout, else stay.
REQ-017 KEY_ENTRY SHALL use the priority alarm_button -> SET_ALARM_TIME, then time_button -> SET_CURRENT_TIME, then a digit key -> KEY_STORED, then timeout -> SHOW_TIME, else stay.
REQ-018 SHOW_ALARM and SET_ALARM_TIME SHALL return to SHOW_TIME when alarm_button=0; SET_CURRENT_TIME SHALL return when time_button=0.
REQ-019 Outputs SHALL be Moore-decoded from the state register: shift=KEY_STORED; show_new_time=KEY_STORED|KEY_WAITED|KEY_ENTRY; show_a=SHOW_ALARM; load_new_a=SET_ALARM_TIME; load_new_c=SET_CURRENT_TIME; at most one of show_a/load_new_a/load_new_c high.
REQ-020 shift SHALL rise on the cycle after the first cycle a digit is sampled; a held key SHALL produce exactly one shift.
REQ-021 A 4-bit timeout counter SHALL be cleared in every state other than KEY_WAITED and KEY_ENTRY, and SHALL increment on one_second while in those two states.
REQ-022 Timeout SHALL be when counter = TIMEOUT_SEC-1 and one_second=1; the counter SHALL never wrap.
REQ-023 Passing through KEY_STORED SHALL clear the counter, so each new digit restarts the full timeout.
REQ-024 The KEY_WAITED -> KEY_ENTRY transition SHALL NOT clear the counter; held time and released time accumulate.
REQ-025 A digit and timeout in the same KEY_ENTRY cycle SHALL resolve to KEY_STORED.
REQ-026 An unused state encoding SHALL recover to SHOW_TIME on the next clock.

Reset
REQ-027 With reset=1 at a rising edge: state=SHOW_TIME, counter=0, all outputs 0 from the next cycle, including mid-entry or while loading.
REQ-028 Reset SHALL take priority over every input in the same cycle.

Structure
REQ-029 Shared package aclk_pkg SHALL hold the state encoding, NOKEY=4'd10 and the digit-test helper, which are reused by the key register and display blocks.
REQ-030 The timeout counter MAY be the sub-module aclk_timeout_cnt (inputs clear, tick, limit; output expired); the FSM stays in aclk_fsm.

Verification
REQ-031 Reset, then key=3 for 4 cycles, then NOKEY -> shift high exactly 1 cycle (cycle 2), state KEY_ENTRY, show_new_time=1.
REQ-032 Enter digits 1,2,3,4, then time_button=1 for 3 cycles -> 4 shift pulses; load_new_c=1 for those 3 cycles; SHOW_TIME after release.
REQ-033 In KEY_ENTRY, 10 one_second pulses with no key -> SHOW_TIME on the 10th pulse; a digit on pulse 9 restarts the count.
REQ-034 In SHOW_TIME, alarm_button and time_button both high -> SHOW_ALARM, show_a=1; load_new_c stays 0.
REQ-035 In KEY_ENTRY, alarm_button and a digit in the same cycle -> SET_ALARM_TIME, no shift; key=12 in SHOW_TIME -> no state change.
REQ-036 reset asserted during SET_ALARM_TIME with alarm_button held -> load_new_a=0 the next cycle, state SHOW_TIME, then SHOW_ALARM on the first cycle after reset deasserts.
